// File: rtl/mult_div_seq_if.sv
// mult_div_seq_if: operand/handshake/result bundle between the control FSM and the multiply/divide unit
interface mult_div_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, signed_mode, a, b, input busy, done, div_zero, hi, lo);
  modport slave (input start, op, signed_mode, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mult_div_seq.sv
// mult_div_seq: sequential radix-2 shift-add multiplier / restoring divider on sign magnitudes, sign fixed in one final cycle
module mult_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic           clk,
  input logic           reset,
  mult_div_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2;
  logic [1:0]         state_q, state_d;
  logic               is_div_q, is_div_d, neg_q, neg_d, sa_q, sa_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, quo_q, quo_d, rem_q, rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, prod;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic               sa, sb, go, ge;
  logic [WIDTH:0]     sum, shifted, diff;
  always_comb begin
    sa = bus.signed_mode & bus.a[WIDTH-1];
    sb = bus.signed_mode & bus.b[WIDTH-1];
    go = bus.start & (bus.op[0] ^ bus.op[1]);
    sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{mplier_q[0]}} & mcand_q};
    // dividend magnitude is shifted out of mcand MSB-first into the partial remainder
    shifted = {rem_q, mcand_q[WIDTH-1]};
    ge = shifted >= {1'b0, mplier_q};
    diff = shifted - {1'b0, mplier_q};
    prod = neg_q ? -acc_q : acc_q;
    state_d = state_q;
    is_div_d = is_div_q;
    neg_d = neg_q;
    sa_d = sa_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    quo_d = quo_q;
    rem_d = rem_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    hi_d = hi_q;
    lo_d = lo_q;
    busy_d = busy_q;
    done_d = 1'b0;
    dz_d = 1'b0;
    if (state_q == IDLE && go) begin
      if (bus.op[1] && bus.b == '0) begin
        done_d = 1'b1;
        dz_d = 1'b1;
      end else begin
        is_div_d = bus.op[1];
        sa_d = sa;
        neg_d = sa ^ sb;
        mcand_d = sa ? -bus.a : bus.a;
        mplier_d = sb ? -bus.b : bus.b;
        acc_d = '0;
        rem_d = '0;
        quo_d = '0;
        cnt_d = CNT_W'(WIDTH);
        busy_d = 1'b1;
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - CNT_W'(1);
      state_d = cnt_q == CNT_W'(1) ? FIX : RUN;
      if (is_div_q) begin
        rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        mcand_d = mcand_q << 1;
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
        mplier_d = mplier_q >> 1;
      end
    end else if (state_q == FIX) begin
      hi_d = is_div_q ? (sa_q ? -rem_q : rem_q) : prod[2*WIDTH-1:WIDTH];
      lo_d = is_div_q ? (neg_q ? -quo_q : quo_q) : prod[WIDTH-1:0];
      done_d = 1'b1;
      busy_d = 1'b0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      is_div_q <= 1'b0;
      neg_q <= 1'b0;
      sa_q <= 1'b0;
      mcand_q <= '0;
      mplier_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      is_div_q <= is_div_d;
      neg_q <= neg_d;
      sa_q <= sa_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q <= dz_d;
    end
  end
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_mult_div_seq.sv
// tb_mult_div_seq: directed vectors on a 32-bit and an 8-bit instance with hand-computed results
module tb_mult_div_seq;
  logic clk = 1'b0;
  logic rst32_n = 1'b0;
  logic rst8_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  mult_div_seq_if #(.WIDTH(32)) if32();
  mult_div_seq_if #(.WIDTH(8)) if8();
  mult_div_seq #(.WIDTH(32)) u32 (.clk(clk), .reset(rst32_n), .bus(if32));
  mult_div_seq #(.WIDTH(8)) u8 (.clk(clk), .reset(rst8_n), .bus(if8));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask
  task automatic run(input bit w8, input logic [1:0] op, input logic sm, input logic [31:0] a, input logic [31:0] b,
                     input int pulse, output int edges, output int bcyc, output logic [31:0] hi, output logic [31:0] lo,
                     output logic dz);
    @(negedge clk);
    if (w8) begin
      if8.start = 1'b1; if8.op = op; if8.signed_mode = sm; if8.a = a[7:0]; if8.b = b[7:0];
    end else begin
      if32.start = 1'b1; if32.op = op; if32.signed_mode = sm; if32.a = a; if32.b = b;
    end
    @(posedge clk);
    #1;
    if32.start = 1'b0; if32.a = ~if32.a; if32.b = 32'h5; if32.op = 2'b00; if32.signed_mode = ~if32.signed_mode;
    if8.start = 1'b0; if8.a = ~if8.a; if8.b = 8'h5; if8.op = 2'b00; if8.signed_mode = ~if8.signed_mode;
    edges = 0;
    bcyc = 0;
    while (!(w8 ? if8.done : if32.done) && edges < 100) begin
      if (w8 ? if8.busy : if32.busy) bcyc++;
      if (edges == pulse) begin
        if8.start = w8; if8.op = 2'b01; if8.a = 8'h3; if8.b = 8'h3;
        if32.start = !w8; if32.op = 2'b01; if32.a = 32'h3; if32.b = 32'h3;
      end else begin
        if8.start = 1'b0;
        if32.start = 1'b0;
      end
      @(posedge clk);
      #1;
      edges++;
    end
    if8.start = 1'b0;
    if32.start = 1'b0;
    hi = w8 ? {24'h0, if8.hi} : if32.hi;
    lo = w8 ? {24'h0, if8.lo} : if32.lo;
    dz = w8 ? if8.div_zero : if32.div_zero;
    check("busy_at_done", w8 ? if8.busy : if32.busy, 0);
    @(posedge clk);
    #1;
    check("done_one_cycle", w8 ? if8.done : if32.done, 0);
    check("dz_one_cycle", w8 ? if8.div_zero : if32.div_zero, 0);
  endtask
  initial begin
    int e, bc, seen;
    logic [31:0] h, l;
    logic z;
    {if32.start, if32.op, if32.signed_mode, if32.a, if32.b} = '0;
    {if8.start, if8.op, if8.signed_mode, if8.a, if8.b} = '0;
    repeat (3) @(negedge clk);
    rst32_n = 1'b1;
    rst8_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_hi32", if32.hi, 0);
    check("rst_lo32", if32.lo, 0);
    check("rst_flags32", {if32.busy, if32.done, if32.div_zero}, 0);
    check("rst_out8", {if8.hi, if8.lo, if8.busy, if8.done, if8.div_zero}, 0);
    @(negedge clk);
    if32.start = 1'b1; if32.op = 2'b00; if32.a = 32'h2; if32.b = 32'h3;
    @(posedge clk);
    #1;
    if32.start = 1'b0;
    check("noop_busy", {if32.busy, if32.done}, 0);
    run(0, 2'b01, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, e, bc, h, l, z);
    check("umul_max_hi", h, 32'hFFFFFFFE);
    check("umul_max_lo", l, 32'h00000001);
    check("umul_latency", e, 33);
    check("umul_busy_cycles", bc, 33);
    run(0, 2'b01, 1, 32'hFFFFFFFD, 32'h7, -1, e, bc, h, l, z);
    check("smul_hi", h, 32'hFFFFFFFF);
    check("smul_lo", l, 32'hFFFFFFEB);
    run(0, 2'b01, 0, 32'hFFFFFFFD, 32'h7, -1, e, bc, h, l, z);
    check("umul_hi", h, 32'h00000006);
    check("umul_lo", l, 32'hFFFFFFEB);
    run(0, 2'b10, 1, 32'hFFFFFFF9, 32'h2, -1, e, bc, h, l, z);
    check("sdiv_quo", l, 32'hFFFFFFFD);
    check("sdiv_rem", h, 32'hFFFFFFFF);
    check("sdiv_latency", e, 33);
    run(0, 2'b10, 0, 32'd100, 32'd7, -1, e, bc, h, l, z);
    check("udiv_quo", l, 32'd14);
    check("udiv_rem", h, 32'd2);
    check("udiv_dz", z, 0);
    run(0, 2'b10, 0, 32'h451, 32'h20, -1, e, bc, h, l, z);
    check("prior_hi", h, 32'h11);
    check("prior_lo", l, 32'h22);
    run(0, 2'b10, 0, 32'd5, 32'd0, -1, e, bc, h, l, z);
    check("dz_flag", z, 1);
    check("dz_latency", e, 0);
    check("dz_no_busy", bc, 0);
    check("dz_hi_hold", h, 32'h11);
    check("dz_lo_hold", l, 32'h22);
    @(negedge clk);
    if32.start = 1'b1; if32.op = 2'b01; if32.signed_mode = 1'b0; if32.a = 32'hFFFFFFFF; if32.b = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    if32.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort_busy_before", if32.busy, 1);
    @(negedge clk);
    rst32_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_hilo", {if32.hi, if32.lo}, 0);
    check("abort_flags", {if32.busy, if32.done, if32.div_zero}, 0);
    @(negedge clk);
    rst32_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (if32.done || if32.busy) seen++;
    end
    check("abort_no_done", seen, 0);
    run(0, 2'b10, 0, 32'd6, 32'd3, -1, e, bc, h, l, z);
    check("post_abort_quo", l, 32'd2);
    check("post_abort_rem", h, 32'd0);
    run(1, 2'b10, 1, 32'h80, 32'hFF, -1, e, bc, h, l, z);
    check("w8_sdiv_quo", l, 32'h80);
    check("w8_sdiv_rem", h, 32'h00);
    check("w8_sdiv_dz", z, 0);
    run(1, 2'b01, 1, 32'h80, 32'h80, -1, e, bc, h, l, z);
    check("w8_smul_hi", h, 32'h40);
    check("w8_smul_lo", l, 32'h00);
    check("w8_smul_latency", e, 9);
    run(1, 2'b01, 0, 32'd5, 32'd6, 3, e, bc, h, l, z);
    check("w8_ignore_hi", h, 32'h00);
    check("w8_ignore_lo", l, 32'd30);
    check("w8_ignore_latency", e, 9);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mult_div_seq.md
# mult_div_seq

Parametrised sequential multiply/divide unit for the multicycle CPU datapath, successor to the fixed 32-bit MultDiv block. It takes two WIDTH-bit operands from the A/B registers and produces a 2·WIDTH-bit product or a quotient/remainder pair. Results go to HI/LO-style outputs. It adds a signed/unsigned mode, a start/busy/done handshake for the control FSM, and a registered divide-by-zero flag.

## Interface
- WIDTH, 32, operand width in bits (≥4)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- op  in  2  01 = multiply, 10 = divide; 00/11 = no-op (start ignored)
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when hi/lo (or div_zero) are valid
- hi  out  WIDTH  product upper half / remainder
- lo  out  WIDTH  product lower half / quotient
- div_zero  out  1  divide by zero; one-cycle pulse coincident with done

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - On the edge sampling start=1 with op∈{01,10} (E0): latch op and signed_mode.
  - Latch operand magnitudes (negate when signed_mode and MSB set) and result sign bits.
  - Clear accumulator and quotient; counter := WIDTH; busy := 1; go to RUN.
- Divide with b==0 at E0:
  - No RUN.
  - done := 1 and div_zero := 1 for one cycle; hi/lo unchanged; stay in IDLE; busy stays 0.
- RUN, multiply: radix-2 shift-add on a 2·WIDTH-bit accumulator, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits.
- RUN: counter decrements each edge; at 0, go to FIX.
- FIX, one edge:
  - Multiply: negate the 2·WIDTH product if the operand signs differ (signed only).
  - Divide: negate the quotient if the signs differ. The remainder takes the dividend's sign.
  - Write hi/lo; done := 1; busy := 0; go to IDLE.
- Signed corner cases, wrap-around and no fault:
  - (−2^(W−1)) / (−1) → lo = 2^(W−1) bit pattern, hi = 0.
  - (−2^(W−1))·(−2^(W−1)) → hi = 2^(W−2), lo = 0.
- a, b, op and signed_mode may change after E0 without affecting the operation.
- start while busy is ignored; no queueing.

## Timing
- Reset (reset==0 at any edge, including mid-RUN/FIX):
  - State IDLE; hi = lo = 0; busy = done = div_zero = 0.
  - Any in-flight operation is aborted with no done pulse.
- Latency:
  - Start sampled at E0; busy high after E0.
  - Iterations occur on E1..E_WIDTH.
  - hi/lo update, done=1 and busy=0 after E_(WIDTH+1). For WIDTH=32 that is 33 edges after E0.
- done and div_zero are high for exactly one cycle. hi/lo hold until the next completed operation or reset.
- Back-to-back: start may be asserted in the cycle where done=1. It is accepted on the next edge, giving a minimum issue interval of WIDTH+2 cycles.
- Divide-by-zero: done/div_zero visible after E0 (1-edge latency).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WIDTH=32, unsigned multiply 0xFFFFFFFF·0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; done exactly 33 edges after E0; busy high for those 33 cycles.
- Signed multiply −3·7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Unsigned multiply of the same bit patterns → hi=0x00000006, lo=0xFFFFFFEB.
- Signed divide −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Unsigned divide 100/7 → lo=14, hi=2.
- Divide by zero, a=5, b=0, with prior hi/lo=0x11/0x22 → done and div_zero pulse one cycle after E0; hi/lo remain 0x11/0x22; busy never asserts.
- Mid-operation abort:
  - reset=0 at E10 of a multiply → all outputs 0, no done pulse.
  - A fresh 6/3 divide issued afterwards → lo=2, hi=0.
- WIDTH=8 instance:
  - Signed −128/−1 → lo=0x80, hi=0x00.
  - Signed −128·−128 → hi=0x40, lo=0x00; done 9 edges after E0.
  - start pulsed during busy → ignored, and the result is unchanged.
